// File: rtl/d_ff_reg.sv
// d_ff_reg: parameterised D register / delay line with synchronous reset and clock enable.
// Q is the last of DEPTH stages; Qn is its bitwise complement.
module d_ff_reg #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = D;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++) stage_q[i] <= reset ? RESET_VAL : stage_d[i];
  assign Q  = stage_q[DEPTH-1];
  assign Qn = ~Q;
endmodule

// File: tb/tb_d_ff_reg.sv
// tb_d_ff_reg: directed checks of d_ff_reg as plain flop, enabled hold register and 3-stage delay line.
module tb_d_ff_reg;
  logic clk;
  int checks = 0;
  int failures = 0;
  logic       ra, ea, da, qa, qna;
  logic       rb, eb;
  logic [7:0] db, qb, qnb;
  logic       rc, ec;
  logic [7:0] dc, qc, qnc;
  logic       rf, ef;
  logic [7:0] df, qf, qnf;
  d_ff_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_a (
    .clk(clk), .reset(ra), .en(ea), .D(da), .Q(qa), .Qn(qna));
  d_ff_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .reset(rb), .en(eb), .D(db), .Q(qb), .Qn(qnb));
  d_ff_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_c (
    .clk(clk), .reset(rc), .en(ec), .D(dc), .Q(qc), .Qn(qnc));
  d_ff_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hFF)) u_f (
    .clk(clk), .reset(rf), .en(ef), .D(df), .Q(qf), .Qn(qnf));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] dl_exp [6];
    dl_exp = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    ra = 1; ea = 1; da = 1;
    rb = 1; eb = 1; db = 8'h55;
    rc = 1; ec = 1; dc = 8'h77;
    rf = 1; ef = 1; df = 8'h11;
    tick();
    chk("rst_q", {7'd0, qa}, 8'd0);
    chk("rst_qn", {7'd0, qna}, 8'd1);
    chk("rst_b", qb, 8'h00);
    chk("rst_f", qf, 8'hFF);
    chk("rst_fn", qnf, 8'h00);
    tick();
    chk("rst_hold_q", {7'd0, qa}, 8'd0);
    chk("rst_hold_c", qc, 8'h00);
    ra = 0;
    for (int k = 0; k < 4; k++) begin
      da = k[0];
      tick();
      chk("cap_q", {7'd0, qa}, {7'd0, k[0]});
      chk("cap_qn", {7'd0, qna}, {7'd0, ~k[0]});
      da = ~k[0];
      #2;
      chk("cap_stable", {7'd0, qa}, {7'd0, k[0]});
    end
    rb = 0; db = 8'hA5;
    tick();
    chk("en_cap", qb, 8'hA5);
    eb = 0; db = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_hold", qb, 8'hA5);
    end
    eb = 1;
    tick();
    chk("en_resume", qb, 8'h3C);
    chk("en_resume_n", qnb, 8'hC3);
    rc = 0;
    for (int k = 0; k < 6; k++) begin
      dc = (k < 4) ? 8'(k + 1) : 8'd4;
      tick();
      chk("delay", qc, dl_exp[k]);
    end
    rf = 0;
    for (int k = 1; k <= 3; k++) begin
      df = 8'(k);
      tick();
    end
    chk("flush_pre", qf, 8'd1);
    rf = 1; df = 8'h09;
    tick();
    chk("flush_rst", qf, 8'hFF);
    chk("flush_rst_n", qnf, 8'h00);
    rf = 0; df = 8'h07;
    tick();
    chk("flush_1", qf, 8'hFF);
    tick();
    chk("flush_2", qf, 8'hFF);
    tick();
    chk("flush_3", qf, 8'h07);
    #2 rf = 1;
    #3 rf = 0;
    tick();
    chk("async_imm", qf, 8'h07);
    chk("async_imm_n", qnf, 8'hF8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
